// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux arbiter.
// Holds state encoding, requester sizing and the rotating first-set search.
package rr_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Lowest offset from start wins, so scan offsets high to low.
    function automatic pick_t first_set(
        input logic [0:NUM_REQ-1] vec,
        input logic [SEL_W-1:0]   start
    );
        pick_t            p;
        logic [SEL_W-1:0] idx;
        p = '0;
        for (int n = NUM_REQ - 1; n >= 0; n--) begin
            idx = start + SEL_W'(n);
            if (vec[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    function automatic logic [0:NUM_REQ-1] onehot(
        input logic [SEL_W-1:0] idx
    );
        logic [0:NUM_REQ-1] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux_core.sv
// Combinational 4:1 single-bit mux shared by all requesters.
// Select 0 picks I[0], select 3 picks I[3].
module four_to_one_mux_core
    import rr_mux_arbiter_pkg::*;
(
    input  logic [0:NUM_REQ-1] I,
    input  logic [SEL_W-1:0]   Sel,
    output logic               Y
);

    always_comb begin
        Y = 1'b0;
        unique case (Sel)
            2'd0: Y = I[0];
            2'd1: Y = I[1];
            2'd2: Y = I[2];
            2'd3: Y = I[3];
            default: Y = 1'b0;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux; registers the owner's bit.
// Release on Last, early withdraw or hold expiry hands over with no bubble.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [0:3]       Req,
    input  logic [0:3]       Last,
    input  logic [0:3]       I,
    output logic [0:3]       Grant,
    output logic [0:1]       Select_Line,
    output logic             Out,
    output logic             Out_Valid,
    output logic             Busy
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [0:NUM_REQ-1] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;

    logic               mux_out;
    logic               release_c;
    pick_t              pick;

    four_to_one_mux_core u_mux (
        .I   (I),
        .Sel (sel_q),
        .Y   (mux_out)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        release_c   = 1'b0;
        pick        = '0;
        unique case (state_q)
            IDLE: begin
                pick = first_set(Req, ptr_q);
                if (pick.found) begin
                    state_d = GRANT;
                    grant_d = onehot(pick.idx);
                    sel_d   = pick.idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                out_valid_d = Req[sel_q];
                if (Req[sel_q]) begin
                    out_d = mux_out;
                end
                release_c = !Req[sel_q] || Last[sel_q]
                         || (hold_q == HOLD_MAX);
                if (release_c) begin
                    // The releasing owner is masked so it cannot win back-to-back.
                    ptr_d = sel_q + 2'd1;
                    pick  = first_set(Req & ~onehot(sel_q), sel_q + 2'd1);
                    if (pick.found) begin
                        grant_d = onehot(pick.idx);
                        sel_d   = pick.idx;
                        hold_d  = '0;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            grant_q     <= '0;
            sel_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Grant       = grant_q;
    assign Select_Line = sel_q;
    assign Out         = out_q;
    assign Out_Valid   = out_valid_q;
    assign Busy        = (state_q == GRANT);

endmodule
